shift_register: RTL and testbench
=================================

# shift_register

Universal parallel-load, bidirectional shift register (74194-style) with a width parameter and a default width of 4. It gives datapath and demo logic one register that can load a word, shift in either direction with serial fill, or hold. The block is fully synchronous to one clock, with no combinational path from inputs to `A`.

## Interface
- `WIDTH`, default 4, register width in bits (≥ 2).
- `clk`  input  1  rising-edge clock.
- `clear`  input  1  reset: synchronous, active-low; `clear=0` at a rising edge zeroes the register.
- `I`  input  WIDTH  parallel load data.
- `s`  input  2  mode select.
- `SIL`  input  1  serial input entering the MSB end during shift-right.
- `SIR`  input  1  serial input entering the LSB end during shift-left.
- `A`  output  WIDTH  register contents, driven directly from flops.

## Operation
- Mode encoding for `s`:
  - 00: parallel load, `A <= I`.
  - 01: shift right (toward LSB), `A <= {SIL, A[WIDTH-1:1]}`.
  - 10: shift left (toward MSB), `A <= {A[WIDTH-2:0], SIR}`.
  - 11: hold, `A <= A`.
- Reset has priority. `clear=0` forces `A <= 0` regardless of `s`, `I`, `SIL` and `SIR`.
- `SIL` is ignored in every mode except 01. `SIR` is ignored in every mode except 10. `I` is ignored in every mode except 00.
- `s` is a full decode. There are no illegal codes and no state machine beyond the register itself.
- Per-bit next state:
  - bit k selects from `I[k]`, `A[k+1]` (or `SIL` at the MSB), `A[k-1]` (or `SIR` at the LSB), or `A[k]`.

## Timing
- All updates occur on the rising edge of `clk`. Latency is one cycle from sampled inputs to the new `A`.
- Reset value: `A = 0`.
  - At power-up `A` is undefined until the first edge with `clear=0`.
- If `clear` is asserted mid-shift, `A` becomes 0 at that edge. The selected mode resumes from 0 at the first edge after `clear` returns high.
- Changing `s` between edges has no effect until the next edge. The value sampled at the edge decides the operation.
- Boundary bits:
  - During a right shift, the LSB is discarded and the MSB takes `SIL`.
  - During a left shift, the MSB is discarded and the LSB takes `SIR`.
  - After WIDTH consecutive shifts, `A` equals the serial-fill value in every bit.

## Structure
- Shared package `shift_register_pkg`:
  - mode constants `MODE_LOAD=2'b00`, `MODE_SHR=2'b01`, `MODE_SHL=2'b10`, `MODE_HOLD=2'b11`;
  - optionally a `mode_t` typedef over these.
- One sub-module, `shift_register_cell`: a single bit made of a 4:1 mux plus a flop with synchronous active-low clear. It takes inputs `load_d`, `right_d`, `left_d`, `s`, `clk`, `clear`.
- The top level instantiates WIDTH cells via generate. It wires neighbor bits and `SIL`/`SIR` at the ends.

## Test plan
All scenarios use WIDTH=4.
- Reset: `clear=0` for one edge with `s=00`, `I=1111` -> `A=0000`. Reset overrides load.
- Load then hold: `I=1011`, `s=00` for one edge -> `A=1011`. Then `s=11` for 2 edges -> `A` stays `1011`.
- Shift right, fill with 1: from `1011`, `s=01`, `SIL=1` for 4 edges -> `A` goes 1101, 1110, 1111, 1111.
- Shift left with both fills:
  - from `1111`, `s=10`, `SIR=0` for 4 edges -> 1110, 1100, 1000, 0000;
  - then `SIR=1` for 4 edges -> 0001, 0011, 0111, 1111.
- Reload and shift right, fill with 0: `I=1100`, `s=00` -> `1100`. Then `s=01`, `SIL=0` for 4 edges -> 0110, 0011, 0001, 0000.
- Reset mid-shift: while shifting left with `SIR=1` from `0011`, pulse `clear=0` for one edge -> `0000`. Next edge with `clear=1` -> `0001`.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Mode encoding shared by the universal shift register and its bit cell.
// Every 2-bit code is a legal operation, so no illegal-code handling exists.
package shift_register_pkg;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        M_LOAD = MODE_LOAD,
        M_SHR  = MODE_SHR,
        M_SHL  = MODE_SHL,
        M_HOLD = MODE_HOLD
    } mode_t;

    // Next value of one bit given its four candidate sources.
    function automatic logic cell_next(
        input logic [1:0] mode,
        input logic       load_d,
        input logic       right_d,
        input logic       left_d,
        input logic       hold_d
    );
        logic nxt;
        nxt = hold_d;
        case (mode)
            MODE_LOAD: nxt = load_d;
            MODE_SHR:  nxt = right_d;
            MODE_SHL:  nxt = left_d;
            MODE_HOLD: nxt = hold_d;
            default:   nxt = hold_d;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/shift_register_cell.sv
// One register bit: 4:1 source mux feeding a flop with synchronous active-low clear.
// right_d is the upper neighbour (or SIL), left_d the lower neighbour (or SIR).
module shift_register_cell
    import shift_register_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] s,
    input  logic       load_d,
    input  logic       right_d,
    input  logic       left_d,
    output logic       q
);

    always_ff @(posedge clk) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            q <= cell_next(s, load_d, right_d, left_d, q);
        end
    end

endmodule

// File: rtl/shift_register.sv
// 74194-style universal shift register: parallel load, shift right/left with
// serial fill, or hold. A comes straight from the cell flops.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       s,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] A
);

    // Serial inputs sit at the open ends of the neighbour chain.
    logic [WIDTH-1:0] right_src;
    logic [WIDTH-1:0] left_src;

    assign right_src = {SIL, A[WIDTH-1:1]};
    assign left_src  = {A[WIDTH-2:0], SIR};

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        shift_register_cell u_cell (
            .clk     (clk),
            .clear   (clear),
            .s       (s),
            .load_d  (I[k]),
            .right_d (right_src[k]),
            .left_d  (left_src[k]),
            .q       (A[k])
        );
    end

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register (WIDTH=4): directed vectors with fixed
// expected words, then random traffic checked against a behavioural model.
module tb_shift_register;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] I;
    logic [1:0] s;
    logic       SIL;
    logic       SIR;
    logic [3:0] A;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] mdl;

    shift_register #(.WIDTH(4)) dut (
        .clk   (clk),
        .clear (clear),
        .I     (I),
        .s     (s),
        .SIL   (SIL),
        .SIR   (SIR),
        .A     (A)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: A=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, push the expectation, compare just after the rising edge.
    task automatic step(input logic c, input logic [1:0] m, input logic [3:0] i,
                        input logic l, input logic r, input logic [3:0] exp, input string tag);
        logic [3:0] e;
        string      t;
        @(negedge clk);
        clear = c; s = m; I = i; SIL = l; SIR = r;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, A, e);
    endtask

    initial begin
        clear = 1'b1; s = 2'b11; I = 4'b0000; SIL = 1'b0; SIR = 1'b0;

        step(0, 2'b00, 4'b1111, 1, 1, 4'b0000, "reset_over_load");
        step(1, 2'b00, 4'b1011, 0, 0, 4'b1011, "load");
        step(1, 2'b11, 4'b0000, 1, 1, 4'b1011, "hold1");
        step(1, 2'b11, 4'b0101, 1, 1, 4'b1011, "hold2");

        step(1, 2'b01, 4'b0000, 1, 0, 4'b1101, "shr1_a");
        step(1, 2'b01, 4'b0000, 1, 0, 4'b1110, "shr1_b");
        step(1, 2'b01, 4'b0000, 1, 0, 4'b1111, "shr1_c");
        step(1, 2'b01, 4'b0000, 1, 0, 4'b1111, "shr1_d");

        step(1, 2'b10, 4'b1111, 1, 0, 4'b1110, "shl0_a");
        step(1, 2'b10, 4'b1111, 1, 0, 4'b1100, "shl0_b");
        step(1, 2'b10, 4'b1111, 1, 0, 4'b1000, "shl0_c");
        step(1, 2'b10, 4'b1111, 1, 0, 4'b0000, "shl0_d");
        step(1, 2'b10, 4'b0000, 0, 1, 4'b0001, "shl1_a");
        step(1, 2'b10, 4'b0000, 0, 1, 4'b0011, "shl1_b");
        step(1, 2'b10, 4'b0000, 0, 1, 4'b0111, "shl1_c");
        step(1, 2'b10, 4'b0000, 0, 1, 4'b1111, "shl1_d");

        step(1, 2'b00, 4'b1100, 1, 1, 4'b1100, "reload");
        step(1, 2'b01, 4'b1111, 0, 1, 4'b0110, "shr0_a");
        step(1, 2'b01, 4'b1111, 0, 1, 4'b0011, "shr0_b");
        step(1, 2'b01, 4'b1111, 0, 1, 4'b0001, "shr0_c");
        step(1, 2'b01, 4'b1111, 0, 1, 4'b0000, "shr0_d");

        step(1, 2'b10, 4'b0000, 0, 1, 4'b0001, "pre_mid_a");
        step(1, 2'b10, 4'b0000, 0, 1, 4'b0011, "pre_mid_b");
        step(0, 2'b10, 4'b1111, 1, 1, 4'b0000, "clear_mid_shift");
        step(1, 2'b10, 4'b1111, 1, 1, 4'b0001, "resume_after_clear");

        step(1, 2'b00, 4'b1001, 0, 0, 4'b1001, "load_b");
        step(0, 2'b11, 4'b0110, 1, 1, 4'b0000, "clear_over_hold");

        mdl = 4'b0000;
        for (int n = 0; n < 60; n++) begin
            logic       c;
            logic [1:0] m;
            logic [3:0] i;
            logic       l;
            logic       r;
            c = ($urandom_range(0, 9) != 0);
            m = 2'($urandom_range(0, 3));
            i = 4'($urandom_range(0, 15));
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!c)               mdl = 4'b0000;
            else if (m == 2'b00)  mdl = i;
            else if (m == 2'b01)  mdl = (mdl >> 1) | {l, 3'b000};
            else if (m == 2'b10)  mdl = (mdl << 1) | {3'b000, r};
            step(c, m, i, l, r, mdl, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
